ex_stage: RTL

- Execute stage of the 5-stage MIPS pipeline; the downstream consumer of the forwarding unit's `c_data1_src` / `c_data2_src` selects.
- Contains the forwarded operand muxes, the ALU, a sequential 32-cycle multiplier with HI/LO registers, and the EX/MEM pipeline register.
- Raises `ex_busy` so the hazard logic can hold IF/ID/EX while a `mult`/`multu` iterates.

---
 rtl/pipe_pkg.sv | 49 ++++
 rtl/ex_stage_mult_seq.sv | 78 +++++++
 rtl/ex_stage.sv | 139 +++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the execute stage: ALU op codes, forwarding selects,
// multiplier state encoding and small datapath helpers.
package pipe_pkg;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_NOR   = 4'd5;
    localparam logic [3:0] ALU_SLT   = 4'd6;
    localparam logic [3:0] ALU_SLTU  = 4'd7;
    localparam logic [3:0] ALU_SLL   = 4'd8;
    localparam logic [3:0] ALU_SRL   = 4'd9;
    localparam logic [3:0] ALU_SRA   = 4'd10;
    localparam logic [3:0] ALU_LUI   = 4'd11;
    localparam logic [3:0] ALU_MULT  = 4'd12;
    localparam logic [3:0] ALU_MULTU = 4'd13;
    localparam logic [3:0] ALU_MFHI  = 4'd14;
    localparam logic [3:0] ALU_MFLO  = 4'd15;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    localparam int MUL_CYCLES = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_t;

    function automatic logic [31:0] fwd_sel(input logic [1:0] sel, input logic [31:0] rf,
                                            input logic [31:0] mem_wb, input logic [31:0] ex_mem);
        logic [31:0] res;
        case (sel)
            FWD_MEMWB: res = mem_wb;
            FWD_EXMEM: res = ex_mem;
            default:   res = rf;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] abs32(input logic [31:0] x);
        return x[31] ? (32'd0 - x) : x;
    endfunction

endpackage

// File: rtl/ex_stage_mult_seq.sv
// Iterative shift-add multiplier: magnitudes are multiplied one bit per cycle
// and the sign is reapplied to the 64-bit result.
module mult_seq
    import pipe_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hold,
    output logic        busy,
    output logic        done,
    output logic [63:0] product
);

    mul_state_t  state_r;
    logic [4:0]  cnt_r;
    logic [63:0] mcand_r;
    logic [31:0] mplier_r;
    logic [63:0] acc_r;
    logic        neg_r;

    // Multiplier FSM and datapath; everything freezes while hold is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            cnt_r    <= 5'd0;
            mcand_r  <= 64'd0;
            mplier_r <= 32'd0;
            acc_r    <= 64'd0;
            neg_r    <= 1'b0;
        end else if (!hold) begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        mcand_r  <= {32'd0, is_signed ? abs32(a) : a};
                        mplier_r <= is_signed ? abs32(b) : b;
                        neg_r    <= is_signed & (a[31] ^ b[31]);
                        acc_r    <= 64'd0;
                        cnt_r    <= 5'd0;
                        state_r  <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    if (mplier_r[0]) begin
                        acc_r <= acc_r + mcand_r;
                    end
                    mcand_r  <= mcand_r << 1;
                    mplier_r <= mplier_r >> 1;
                    cnt_r    <= cnt_r + 5'd1;
                    if (cnt_r == 5'(MUL_CYCLES - 1)) begin
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: state_r <= ST_IDLE;
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Busy covers the entry cycle as well, so upstream holds the instruction
    always_comb begin
        busy = 1'b0;
        if (state_r == ST_MUL) begin
            busy = 1'b1;
        end else if (state_r == ST_IDLE) begin
            busy = start;
        end else begin
            busy = 1'b0;
        end
    end

    assign done    = (state_r == ST_DONE);
    assign product = neg_r ? (64'd0 - acc_r) : acc_r;

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: forwarded operand muxes, ALU, sequential multiplier with
// HI/LO, and the EX/MEM pipeline register.
module ex_stage
    import pipe_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_ex_valid,
    input  logic [31:0] id_ex_instru,
    input  logic [31:0] id_ex_rdata1,
    input  logic [31:0] id_ex_rdata2,
    input  logic [31:0] id_ex_imm,
    input  logic [3:0]  c_alu_op,
    input  logic        c_alu_src,
    input  logic        c_reg_dst,
    input  logic        c_reg_write,
    input  logic        c_mem_read,
    input  logic        c_mem_write,
    input  logic        c_mem_to_reg,
    input  logic [1:0]  c_data1_src,
    input  logic [1:0]  c_data2_src,
    input  logic [31:0] fwd_ex_mem_data,
    input  logic [31:0] fwd_mem_wb_data,
    input  logic        mem_stall,
    output logic        ex_mem_valid,
    output logic [31:0] ex_mem_instru,
    output logic [31:0] ex_mem_alu_result,
    output logic [31:0] ex_mem_wdata,
    output logic [4:0]  ex_mem_wreg,
    output logic        ex_mem_RegWrite,
    output logic        ex_mem_MemRead,
    output logic        ex_mem_MemWrite,
    output logic        ex_mem_MemToReg,
    output logic        ex_busy
);

    logic [31:0] alu_a_s;
    logic [31:0] fwd_b_s;
    logic [31:0] alu_b_s;
    logic [31:0] alu_res_s;
    logic [4:0]  shamt_s;
    logic [4:0]  wreg_s;
    logic        start_s;
    logic        mul_done_s;
    logic [63:0] product_s;
    logic [31:0] hi_r;
    logic [31:0] lo_r;

    assign alu_a_s = fwd_sel(c_data1_src, id_ex_rdata1, fwd_mem_wb_data, fwd_ex_mem_data);
    assign fwd_b_s = fwd_sel(c_data2_src, id_ex_rdata2, fwd_mem_wb_data, fwd_ex_mem_data);
    assign alu_b_s = c_alu_src ? id_ex_imm : fwd_b_s;
    assign shamt_s = id_ex_instru[10:6];
    assign wreg_s  = c_reg_dst ? id_ex_instru[15:11] : id_ex_instru[20:16];
    assign start_s = id_ex_valid & ((c_alu_op == ALU_MULT) | (c_alu_op == ALU_MULTU));

    // Single-cycle ALU; multiply ops produce no direct result here
    always_comb begin
        alu_res_s = 32'd0;
        case (c_alu_op)
            ALU_ADD:  alu_res_s = alu_a_s + alu_b_s;
            ALU_SUB:  alu_res_s = alu_a_s - alu_b_s;
            ALU_AND:  alu_res_s = alu_a_s & alu_b_s;
            ALU_OR:   alu_res_s = alu_a_s | alu_b_s;
            ALU_XOR:  alu_res_s = alu_a_s ^ alu_b_s;
            ALU_NOR:  alu_res_s = ~(alu_a_s | alu_b_s);
            ALU_SLT:  alu_res_s = {31'd0, $signed(alu_a_s) < $signed(alu_b_s)};
            ALU_SLTU: alu_res_s = {31'd0, alu_a_s < alu_b_s};
            ALU_SLL:  alu_res_s = alu_b_s << shamt_s;
            ALU_SRL:  alu_res_s = alu_b_s >> shamt_s;
            ALU_SRA:  alu_res_s = $unsigned($signed(alu_b_s) >>> shamt_s);
            ALU_LUI:  alu_res_s = {id_ex_imm[15:0], 16'd0};
            ALU_MFHI: alu_res_s = hi_r;
            ALU_MFLO: alu_res_s = lo_r;
            default:  alu_res_s = 32'd0;
        endcase
    end

    mult_seq u_mult (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_s),
        .is_signed (c_alu_op == ALU_MULT),
        .a         (alu_a_s),
        .b         (alu_b_s),
        .hold      (mem_stall),
        .busy      (ex_busy),
        .done      (mul_done_s),
        .product   (product_s)
    );

    // HI/LO capture the finished product in the DONE cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_r <= 32'd0;
            lo_r <= 32'd0;
        end else if (!mem_stall && mul_done_s) begin
            hi_r <= product_s[63:32];
            lo_r <= product_s[31:0];
        end
    end

    // EX/MEM register: hold on stall, bubble while the multiplier is busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_mem_valid      <= 1'b0;
            ex_mem_instru     <= 32'd0;
            ex_mem_alu_result <= 32'd0;
            ex_mem_wdata      <= 32'd0;
            ex_mem_wreg       <= 5'd0;
            ex_mem_RegWrite   <= 1'b0;
            ex_mem_MemRead    <= 1'b0;
            ex_mem_MemWrite   <= 1'b0;
            ex_mem_MemToReg   <= 1'b0;
        end else if (!mem_stall) begin
            if (ex_busy) begin
                ex_mem_valid      <= 1'b0;
                ex_mem_instru     <= 32'd0;
                ex_mem_alu_result <= 32'd0;
                ex_mem_wdata      <= 32'd0;
                ex_mem_wreg       <= 5'd0;
                ex_mem_RegWrite   <= 1'b0;
                ex_mem_MemRead    <= 1'b0;
                ex_mem_MemWrite   <= 1'b0;
                ex_mem_MemToReg   <= 1'b0;
            end else begin
                ex_mem_valid      <= id_ex_valid;
                ex_mem_instru     <= id_ex_instru;
                ex_mem_alu_result <= alu_res_s;
                ex_mem_wdata      <= fwd_b_s;
                ex_mem_wreg       <= wreg_s;
                ex_mem_RegWrite   <= c_reg_write & id_ex_valid & ~mul_done_s;
                ex_mem_MemRead    <= c_mem_read & id_ex_valid;
                ex_mem_MemWrite   <= c_mem_write & id_ex_valid;
                ex_mem_MemToReg   <= c_mem_to_reg & id_ex_valid;
            end
        end
    end

endmodule
